id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS datapath, directly downstream of the control decoder.
- Each cycle it latches the decoder's EX/M/WB control fields plus the decode-stage data (NPC, register operands, sign-extended immediate, register numbers) and presents them to the execute stage.
- Embeds load-use hazard detection: raises a stall to hold PC and IF/ID, and inserts a bubble (all-zero control) into EX.
- Accepts a branch flush and keeps a saturating bubble counter for lab performance reporting.

Parameters:
- DATA_W, 32, width of NPC, operand and immediate paths
- REG_W, 5, register-number width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- ctlwb_in  in  2  {regwrite, memtoreg} from decoder
- ctlm_in  in  3  {branch, memread, memwrite} from decoder
- ctlex_in  in  4  {regdst, aluop[1:0], alusrc} from decoder
- npc_in  in  DATA_W  incremented PC from IF/ID
- readdat1_in  in  DATA_W  register file port 1 data
- readdat2_in  in  DATA_W  register file port 2 data
- signext_in  in  DATA_W  sign-extended immediate
- rs_in  in  REG_W  instr[25:21]
- rt_in  in  REG_W  instr[20:16]
- rd_in  in  REG_W  instr[15:11]
- flush  in  1  branch taken in MEM; squash the ID instruction
- wb_ctlout  out  2  registered WB control
- m_ctlout  out  3  registered M control
- ex_ctlout  out  4  registered EX control
- npc_out, readdat1_out, readdat2_out, signext_out  out  DATA_W each  registered data
- rt_out, rd_out  out  REG_W each  registered destination candidates
- valid_out  out  1  1 = EX holds a real instruction, 0 = bubble
- stall  out  1  combinational; hold PC and IF/ID this cycle
- bubble_cnt  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset, synchronous on rst=1 at a rising edge: every registered output is 0, including valid_out and bubble_cnt. An all-zero control word is the NOP encoding. rst overrides flush and hazard.
- hazard, combinational: m_ctlout[1] & valid_out & (rt_out != 0) & ((rt_out == rs_in) | (rt_out == rt_in)).
- stall = hazard & ~flush.
- Latency: one cycle from inputs to outputs. No combinational path from any *_in to any *_out. The only combinational output is stall.
- Per edge, priority order:
  1. rst
  2. flush=1: load bubble
  3. hazard=1: load bubble
  4. otherwise: normal load
- Normal load:
  - All *_in captured into the matching *_out.
  - valid_out = 1.
- Bubble load:
  - wb_ctlout, m_ctlout, ex_ctlout and valid_out = 0.
  - Data and register-number outputs still capture their inputs; they are don't-care downstream, but capturing them keeps the logic simple.
  - bubble_cnt increments by 1 and saturates at all-ones; no wrap.
- Flush during a hazard: flush wins. One bubble is counted, stall stays 0 and the squashed instruction is not held.
- Back-to-back hazard: after one bubble, valid_out = 0, so hazard clears by construction. A load-use stall lasts exactly one cycle.
- Decoder 'Z' bits in the don't-care WB/EX positions pass through unmodified on a normal load. The block performs no decoding of control fields beyond m_ctlout[1].

Test Plan:
- Reset: hold rst=1 for 2 cycles with nonzero inputs -> all outputs 0 and stall=0. Release rst with R-type ctl (wb=10, m=000, ex=1100) -> next edge ex_ctlout=1100, wb_ctlout=10, valid_out=1.
- Load-use: cycle 0 load LW (ctl 11/010/0001, rt_in=5). Cycle 1 present rs_in=5 -> stall=1 in cycle 1. Next edge ex/m/wb_ctlout=0, valid_out=0, bubble_cnt=1. Cycle 2 stall=0 and the held instruction loads normally.
- No hazard on $0: LW with rt_in=0, then rs_in=0 -> stall never asserts and bubble_cnt stays 0.
- Flush priority: LW in EX, rt_out=7; present rt_in=7 with flush=1 -> stall=0, next outputs are a bubble, bubble_cnt increments by exactly 1.
- Independent load: LW with rt_in=3, then SW with rs_in=4, rt_in=6 -> no stall; m_ctlout goes 010 then 001.
- Saturation: build with CNT_W=2 and force 5 bubbles -> bubble_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS datapath with load-use hazard
// detection, branch-flush squash and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ctlwb_in,
  input  logic [2:0]        ctlm_in,
  input  logic [3:0]        ctlex_in,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] readdat1_in,
  input  logic [DATA_W-1:0] readdat2_in,
  input  logic [DATA_W-1:0] signext_in,
  input  logic [REG_W-1:0]  rs_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              flush,
  output logic [1:0]        wb_ctlout,
  output logic [2:0]        m_ctlout,
  output logic [3:0]        ex_ctlout,
  output logic [DATA_W-1:0] npc_out,
  output logic [DATA_W-1:0] readdat1_out,
  output logic [DATA_W-1:0] readdat2_out,
  output logic [DATA_W-1:0] signext_out,
  output logic [REG_W-1:0]  rt_out,
  output logic [REG_W-1:0]  rd_out,
  output logic              valid_out,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [1:0]        wb_ctl_q,   wb_ctl_d;
  logic [2:0]        m_ctl_q,    m_ctl_d;
  logic [3:0]        ex_ctl_q,   ex_ctl_d;
  logic [DATA_W-1:0] npc_q,      npc_d;
  logic [DATA_W-1:0] readdat1_q, readdat1_d;
  logic [DATA_W-1:0] readdat2_q, readdat2_d;
  logic [DATA_W-1:0] signext_q,  signext_d;
  logic [REG_W-1:0]  rt_q,       rt_d;
  logic [REG_W-1:0]  rd_q,       rd_d;
  logic              valid_q,    valid_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic hazard;
  logic load_bubble;

  // Load in EX whose destination (never $0) is a source of the ID instruction.
  always_comb begin
    hazard = m_ctl_q[1] & valid_q & (rt_q != '0) &
             ((rt_q == rs_in) | (rt_q == rt_in));
  end

  always_comb begin
    stall       = hazard & ~flush;
    load_bubble = flush | hazard;
  end

  always_comb begin
    npc_d        = npc_in;
    readdat1_d   = readdat1_in;
    readdat2_d   = readdat2_in;
    signext_d    = signext_in;
    rt_d         = rt_in;
    rd_d         = rd_in;
    wb_ctl_d     = ctlwb_in;
    m_ctl_d      = ctlm_in;
    ex_ctl_d     = ctlex_in;
    valid_d      = 1'b1;
    bubble_cnt_d = bubble_cnt_q;
    if (load_bubble) begin
      wb_ctl_d = '0;
      m_ctl_d  = '0;
      ex_ctl_d = '0;
      valid_d  = 1'b0;
      if (bubble_cnt_q != '1) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ctl_q     <= '0;
      m_ctl_q      <= '0;
      ex_ctl_q     <= '0;
      npc_q        <= '0;
      readdat1_q   <= '0;
      readdat2_q   <= '0;
      signext_q    <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      wb_ctl_q     <= wb_ctl_d;
      m_ctl_q      <= m_ctl_d;
      ex_ctl_q     <= ex_ctl_d;
      npc_q        <= npc_d;
      readdat1_q   <= readdat1_d;
      readdat2_q   <= readdat2_d;
      signext_q    <= signext_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  always_comb begin
    wb_ctlout    = wb_ctl_q;
    m_ctlout     = m_ctl_q;
    ex_ctlout    = ex_ctl_q;
    npc_out      = npc_q;
    readdat1_out = readdat1_q;
    readdat2_out = readdat2_q;
    signext_out  = signext_q;
    rt_out       = rt_q;
    rd_out       = rd_q;
    valid_out    = valid_q;
    bubble_cnt   = bubble_cnt_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use stall, $0 exemption,
// flush priority, independent load/store and counter saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, rst_sat;
  logic [1:0]  ctlwb_in;
  logic [2:0]  ctlm_in;
  logic [3:0]  ctlex_in;
  logic [31:0] npc_in, readdat1_in, readdat2_in, signext_in;
  logic [4:0]  rs_in, rt_in, rd_in;
  logic        flush, flush_sat;

  logic [1:0]  wb_ctlout, s_wb;
  logic [2:0]  m_ctlout, s_m;
  logic [3:0]  ex_ctlout, s_ex;
  logic [31:0] npc_out, readdat1_out, readdat2_out, signext_out;
  logic [31:0] s_npc, s_rd1, s_rd2, s_sx;
  logic [4:0]  rt_out, rd_out, s_rt, s_rd;
  logic        valid_out, stall, s_valid, s_stall;
  logic [15:0] bubble_cnt;
  logic [1:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
    .npc_in(npc_in), .readdat1_in(readdat1_in), .readdat2_in(readdat2_in),
    .signext_in(signext_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush),
    .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .ex_ctlout(ex_ctlout), .npc_out(npc_out),
    .readdat1_out(readdat1_out), .readdat2_out(readdat2_out), .signext_out(signext_out),
    .rt_out(rt_out), .rd_out(rd_out), .valid_out(valid_out), .stall(stall),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst_sat), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
    .npc_in(npc_in), .readdat1_in(readdat1_in), .readdat2_in(readdat2_in),
    .signext_in(signext_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush_sat),
    .wb_ctlout(s_wb), .m_ctlout(s_m), .ex_ctlout(s_ex), .npc_out(s_npc),
    .readdat1_out(s_rd1), .readdat2_out(s_rd2), .signext_out(s_sx),
    .rt_out(s_rt), .rd_out(s_rd), .valid_out(s_valid), .stall(s_stall),
    .bubble_cnt(s_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] npc);
    ctlwb_in = wb; ctlm_in = m; ctlex_in = ex;
    rs_in = rs; rt_in = rt; rd_in = rd;
    npc_in = npc;
    readdat1_in = npc ^ 32'h1111_0000;
    readdat2_in = npc ^ 32'h2222_0000;
    signext_in  = npc ^ 32'h3333_0000;
  endtask

  initial begin
    rst = 1'b1; rst_sat = 1'b1; flush = 1'b0; flush_sat = 1'b0;
    @(negedge clk);
    // Reset with nonzero LW-like inputs
    set_instr(2'b11, 3'b010, 4'b0001, 5'd5, 5'd5, 5'd9, 32'h0000_0040);
    tick(); tick();
    check("rst_wb", wb_ctlout, 2'b00);
    check("rst_m", m_ctlout, 3'b000);
    check("rst_ex", ex_ctlout, 4'b0000);
    check("rst_npc", npc_out, 32'h0);
    check("rst_rd1", readdat1_out, 32'h0);
    check("rst_rt", rt_out, 5'd0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_cnt", bubble_cnt, 16'd0);
    check("rst_stall", stall, 1'b0);

    // First R-type after reset
    rst = 1'b0;
    set_instr(2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd3, 32'h0000_0100);
    tick();
    check("rtype_ex", ex_ctlout, 4'b1100);
    check("rtype_wb", wb_ctlout, 2'b10);
    check("rtype_m", m_ctlout, 3'b000);
    check("rtype_valid", valid_out, 1'b1);
    check("rtype_npc", npc_out, 32'h0000_0100);
    check("rtype_rd2", readdat2_out, 32'h2222_0100);
    check("rtype_sx", signext_out, 32'h3333_0100);
    check("rtype_rd", rd_out, 5'd3);

    // Load-use: LW $5, then consumer with rs=5
    set_instr(2'b11, 3'b010, 4'b0001, 5'd1, 5'd5, 5'd0, 32'h0000_0104);
    #1 check("lw_nostall", stall, 1'b0);
    tick();
    check("lw_m", m_ctlout, 3'b010);
    check("lw_rt", rt_out, 5'd5);
    set_instr(2'b10, 3'b000, 4'b1100, 5'd5, 5'd6, 5'd7, 32'h0000_0108);
    #1 check("lu_stall", stall, 1'b1);
    tick();
    check("lu_bub_wb", wb_ctlout, 2'b00);
    check("lu_bub_m", m_ctlout, 3'b000);
    check("lu_bub_ex", ex_ctlout, 4'b0000);
    check("lu_bub_valid", valid_out, 1'b0);
    check("lu_cnt", bubble_cnt, 16'd1);
    check("lu_stall_clear", stall, 1'b0);
    tick();
    check("lu_held_ex", ex_ctlout, 4'b1100);
    check("lu_held_valid", valid_out, 1'b1);
    check("lu_held_rd", rd_out, 5'd7);
    check("lu_held_cnt", bubble_cnt, 16'd1);

    // LW to $0 never stalls
    set_instr(2'b11, 3'b010, 4'b0001, 5'd2, 5'd0, 5'd0, 32'h0000_010C);
    tick();
    check("z_m", m_ctlout, 3'b010);
    set_instr(2'b10, 3'b000, 4'b1100, 5'd0, 5'd0, 5'd4, 32'h0000_0110);
    #1 check("z_stall", stall, 1'b0);
    tick();
    check("z_valid", valid_out, 1'b1);
    check("z_cnt", bubble_cnt, 16'd1);

    // Flush wins over a simultaneous hazard
    set_instr(2'b11, 3'b010, 4'b0001, 5'd2, 5'd7, 5'd0, 32'h0000_0114);
    tick();
    check("fl_rt", rt_out, 5'd7);
    set_instr(2'b10, 3'b000, 4'b1100, 5'd1, 5'd7, 5'd8, 32'h0000_0118);
    flush = 1'b1;
    #1 check("fl_stall", stall, 1'b0);
    tick();
    check("fl_valid", valid_out, 1'b0);
    check("fl_m", m_ctlout, 3'b000);
    check("fl_cnt", bubble_cnt, 16'd2);
    flush = 1'b0;
    #1 check("fl_after_stall", stall, 1'b0);
    tick();
    check("fl_after_valid", valid_out, 1'b1);
    check("fl_after_cnt", bubble_cnt, 16'd2);

    // Independent LW then SW
    set_instr(2'b11, 3'b010, 4'b0001, 5'd1, 5'd3, 5'd0, 32'h0000_0120);
    tick();
    check("ind_lw_m", m_ctlout, 3'b010);
    set_instr(2'b00, 3'b001, 4'b0001, 5'd4, 5'd6, 5'd0, 32'h0000_0124);
    #1 check("ind_stall", stall, 1'b0);
    tick();
    check("ind_sw_m", m_ctlout, 3'b001);
    check("ind_cnt", bubble_cnt, 16'd2);

    // Saturation on the 2-bit counter instance
    rst_sat = 1'b1;
    tick();
    check("sat_rst", s_cnt, 2'd0);
    rst_sat = 1'b0;
    flush_sat = 1'b1;
    tick(); check("sat_1", s_cnt, 2'd1);
    tick(); check("sat_2", s_cnt, 2'd2);
    tick(); check("sat_3", s_cnt, 2'd3);
    tick(); check("sat_4", s_cnt, 2'd3);
    tick(); check("sat_5", s_cnt, 2'd3);
    check("sat_valid", s_valid, 1'b0);
    flush_sat = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
